// File: rtl/ysyx_23060124_rr_xbar.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : ysyx_23060124_rr_xbar
// Purpose  : NM-master x NS-slave AXI4 crossbar. The read and write paths each
//            have their own FSM and their own round-robin arbiter, so one read
//            and one write can be in flight at the same time. Address decode is
//            a first-match over SLV_BASE/SLV_MASK. An unmatched address is
//            served by an internal DECERR responder (RRESP/BRESP = 2'b11).
// Ports    : clock, RESETN          - single clock, synchronous active-low reset
//            M_AR*/M_R*/M_AW*/M_W*/M_B* - NM packed master-side AXI4 channels
//            S_AR*/S_R*/S_AW*/S_W*/S_B* - NS packed slave-side AXI4 channels
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_23060124_rr_xbar #(
    parameter int                NM       = 2,
    parameter int                NS       = 2,
    parameter int                IDW      = 4,
    parameter logic [NS*32-1:0]  SLV_BASE = {32'h0200_0000, 32'h8000_0000},
    parameter logic [NS*32-1:0]  SLV_MASK = {32'hFF00_0000, 32'hF000_0000}
) (
    input  logic                 clock,
    input  logic                 RESETN,
    // master side
    input  logic [NM*32-1:0]     M_ARADDR,
    input  logic [NM*IDW-1:0]    M_ARID,
    input  logic [NM*8-1:0]      M_ARLEN,
    input  logic [NM*3-1:0]      M_ARSIZE,
    input  logic [NM*2-1:0]      M_ARBURST,
    input  logic [NM-1:0]        M_ARVALID,
    output logic [NM-1:0]        M_ARREADY,
    output logic [NM*32-1:0]     M_RDATA,
    output logic [NM*2-1:0]      M_RRESP,
    output logic [NM*IDW-1:0]    M_RID,
    output logic [NM-1:0]        M_RLAST,
    output logic [NM-1:0]        M_RVALID,
    input  logic [NM-1:0]        M_RREADY,
    input  logic [NM*32-1:0]     M_AWADDR,
    input  logic [NM*IDW-1:0]    M_AWID,
    input  logic [NM*8-1:0]      M_AWLEN,
    input  logic [NM*3-1:0]      M_AWSIZE,
    input  logic [NM*2-1:0]      M_AWBURST,
    input  logic [NM-1:0]        M_AWVALID,
    output logic [NM-1:0]        M_AWREADY,
    input  logic [NM*32-1:0]     M_WDATA,
    input  logic [NM*4-1:0]      M_WSTRB,
    input  logic [NM-1:0]        M_WLAST,
    input  logic [NM-1:0]        M_WVALID,
    output logic [NM-1:0]        M_WREADY,
    output logic [NM*2-1:0]      M_BRESP,
    output logic [NM*IDW-1:0]    M_BID,
    output logic [NM-1:0]        M_BVALID,
    input  logic [NM-1:0]        M_BREADY,
    // slave side
    output logic [NS*32-1:0]     S_ARADDR,
    output logic [NS*IDW-1:0]    S_ARID,
    output logic [NS*8-1:0]      S_ARLEN,
    output logic [NS*3-1:0]      S_ARSIZE,
    output logic [NS*2-1:0]      S_ARBURST,
    output logic [NS-1:0]        S_ARVALID,
    input  logic [NS-1:0]        S_ARREADY,
    input  logic [NS*32-1:0]     S_RDATA,
    input  logic [NS*2-1:0]      S_RRESP,
    input  logic [NS*IDW-1:0]    S_RID,
    input  logic [NS-1:0]        S_RLAST,
    input  logic [NS-1:0]        S_RVALID,
    output logic [NS-1:0]        S_RREADY,
    output logic [NS*32-1:0]     S_AWADDR,
    output logic [NS*IDW-1:0]    S_AWID,
    output logic [NS*8-1:0]      S_AWLEN,
    output logic [NS*3-1:0]      S_AWSIZE,
    output logic [NS*2-1:0]      S_AWBURST,
    output logic [NS-1:0]        S_AWVALID,
    input  logic [NS-1:0]        S_AWREADY,
    output logic [NS*32-1:0]     S_WDATA,
    output logic [NS*4-1:0]      S_WSTRB,
    output logic [NS-1:0]        S_WLAST,
    output logic [NS-1:0]        S_WVALID,
    input  logic [NS-1:0]        S_WREADY,
    input  logic [NS*2-1:0]      S_BRESP,
    input  logic [NS*IDW-1:0]    S_BID,
    input  logic [NS-1:0]        S_BVALID,
    output logic [NS-1:0]        S_BREADY
);

    localparam int c_mw = (NM > 1) ? $clog2(NM) : 1;
    localparam int c_sw = (NS > 1) ? $clog2(NS) : 1;

    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA}         rstate_t;
    typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} wstate_t;

    // Round-robin pick: the search starts at 'prio' (the master after the
    // last completed grant). Scanning offsets downward lets the smallest
    // offset overwrite the others, so the closest requester wins.
    function automatic logic [c_mw-1:0] rr_pick(input logic [NM-1:0] req,
                                                input logic [c_mw-1:0] prio);
        logic [c_mw-1:0] pick;
        pick = prio;
        for (int i = NM - 1; i >= 0; i--) begin
            if (req[(int'(prio) + i) % NM]) pick = c_mw'((int'(prio) + i) % NM);
        end
        return pick;
    endfunction

    // Returns {decode_error, slave_index}; lowest matching slave wins.
    function automatic logic [c_sw:0] addr_decode(input logic [31:0] addr);
        logic [c_sw:0] res;
        res = {1'b1, {c_sw{1'b0}}};
        for (int s = NS - 1; s >= 0; s--) begin
            if ((addr & SLV_MASK[32*s +: 32]) == SLV_BASE[32*s +: 32])
                res = {1'b0, c_sw'(s)};
        end
        return res;
    endfunction

    function automatic logic [c_mw-1:0] next_prio(input logic [c_mw-1:0] g);
        return (g == c_mw'(NM - 1)) ? '0 : g + 1'b1;
    endfunction

    // ------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------
    rstate_t          r_rstate, w_rstate_nxt;
    logic [c_mw-1:0]  r_rprio, r_rgnt, w_rarb;
    logic [c_sw-1:0]  r_rslv;
    logic             r_rerr;
    logic [7:0]       r_rlen, r_rcnt;
    logic [IDW-1:0]   r_rid;
    logic [c_sw:0]    w_rdec;
    logic             w_ar_hs, w_r_hs, w_rlast;

    assign w_rarb = rr_pick(M_ARVALID, r_rprio);
    assign w_rdec = addr_decode(M_ARADDR[32*int'(w_rarb) +: 32]);

    always_ff @(posedge clock) begin
        if (!RESETN) r_rstate <= R_IDLE;
        else         r_rstate <= w_rstate_nxt;
    end

    always_ff @(posedge clock) begin
        if (!RESETN) begin
            r_rprio <= '0;
            r_rgnt  <= '0;
            r_rslv  <= '0;
            r_rerr  <= 1'b0;
            r_rlen  <= '0;
            r_rcnt  <= '0;
            r_rid   <= '0;
        end else begin
            if (r_rstate == R_IDLE && |M_ARVALID) begin
                r_rgnt           <= w_rarb;
                {r_rerr, r_rslv} <= w_rdec;
            end
            if (r_rstate == R_ADDR && w_ar_hs) begin
                r_rlen <= M_ARLEN[8*int'(r_rgnt) +: 8];
                r_rid  <= M_ARID[IDW*int'(r_rgnt) +: IDW];
                r_rcnt <= '0;
            end
            if (r_rstate == R_DATA && w_r_hs) begin
                r_rcnt <= r_rcnt + 8'd1;
                if (w_rlast) r_rprio <= next_prio(r_rgnt);
            end
        end
    end

    always_comb begin
        w_rstate_nxt = r_rstate;
        w_ar_hs      = 1'b0;
        w_r_hs       = 1'b0;
        w_rlast      = 1'b0;
        M_ARREADY    = '0;
        M_RDATA      = '0;
        M_RRESP      = '0;
        M_RID        = '0;
        M_RLAST      = '0;
        M_RVALID     = '0;
        S_ARADDR     = '0;
        S_ARID       = '0;
        S_ARLEN      = '0;
        S_ARSIZE     = '0;
        S_ARBURST    = '0;
        S_ARVALID    = '0;
        S_RREADY     = '0;
        case (r_rstate)
            R_IDLE: begin
                if (|M_ARVALID) w_rstate_nxt = R_ADDR;
            end
            R_ADDR: begin
                if (r_rerr) begin
                    M_ARREADY[r_rgnt] = 1'b1;
                end else begin
                    S_ARVALID[r_rslv]                  = M_ARVALID[r_rgnt];
                    S_ARADDR[32*int'(r_rslv) +: 32]    = M_ARADDR[32*int'(r_rgnt) +: 32];
                    S_ARID[IDW*int'(r_rslv) +: IDW]    = M_ARID[IDW*int'(r_rgnt) +: IDW];
                    S_ARLEN[8*int'(r_rslv) +: 8]       = M_ARLEN[8*int'(r_rgnt) +: 8];
                    S_ARSIZE[3*int'(r_rslv) +: 3]      = M_ARSIZE[3*int'(r_rgnt) +: 3];
                    S_ARBURST[2*int'(r_rslv) +: 2]     = M_ARBURST[2*int'(r_rgnt) +: 2];
                    M_ARREADY[r_rgnt]                  = S_ARREADY[r_rslv];
                end
                w_ar_hs = M_ARVALID[r_rgnt] & (r_rerr | S_ARREADY[r_rslv]);
                if (w_ar_hs) w_rstate_nxt = R_DATA;
            end
            R_DATA: begin
                if (r_rerr) begin
                    // Internal responder: zero data, DECERR, one beat per cycle.
                    w_rlast                          = (r_rcnt == r_rlen);
                    M_RVALID[r_rgnt]                 = 1'b1;
                    M_RRESP[2*int'(r_rgnt) +: 2]     = 2'b11;
                    M_RID[IDW*int'(r_rgnt) +: IDW]   = r_rid;
                    M_RLAST[r_rgnt]                  = w_rlast;
                end else begin
                    w_rlast                          = S_RLAST[r_rslv];
                    M_RVALID[r_rgnt]                 = S_RVALID[r_rslv];
                    M_RDATA[32*int'(r_rgnt) +: 32]   = S_RDATA[32*int'(r_rslv) +: 32];
                    M_RRESP[2*int'(r_rgnt) +: 2]     = S_RRESP[2*int'(r_rslv) +: 2];
                    M_RID[IDW*int'(r_rgnt) +: IDW]   = S_RID[IDW*int'(r_rslv) +: IDW];
                    M_RLAST[r_rgnt]                  = S_RLAST[r_rslv];
                    S_RREADY[r_rslv]                 = M_RREADY[r_rgnt];
                end
                w_r_hs = M_RREADY[r_rgnt] & (r_rerr | S_RVALID[r_rslv]);
                if (w_r_hs && w_rlast) w_rstate_nxt = R_IDLE;
            end
            default: w_rstate_nxt = R_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Write path
    // ------------------------------------------------------------------
    wstate_t          r_wstate, w_wstate_nxt;
    logic [c_mw-1:0]  r_wprio, r_wgnt, w_warb;
    logic [c_sw-1:0]  r_wslv;
    logic             r_werr;
    logic [IDW-1:0]   r_wid;
    logic [c_sw:0]    w_wdec;
    logic             w_aw_hs, w_w_hs, w_b_hs;

    assign w_warb = rr_pick(M_AWVALID, r_wprio);
    assign w_wdec = addr_decode(M_AWADDR[32*int'(w_warb) +: 32]);

    always_ff @(posedge clock) begin
        if (!RESETN) r_wstate <= W_IDLE;
        else         r_wstate <= w_wstate_nxt;
    end

    always_ff @(posedge clock) begin
        if (!RESETN) begin
            r_wprio <= '0;
            r_wgnt  <= '0;
            r_wslv  <= '0;
            r_werr  <= 1'b0;
            r_wid   <= '0;
        end else begin
            if (r_wstate == W_IDLE && |M_AWVALID) begin
                r_wgnt           <= w_warb;
                {r_werr, r_wslv} <= w_wdec;
            end
            if (r_wstate == W_ADDR && w_aw_hs)
                r_wid <= M_AWID[IDW*int'(r_wgnt) +: IDW];
            if (r_wstate == W_RESP && w_b_hs)
                r_wprio <= next_prio(r_wgnt);
        end
    end

    always_comb begin
        w_wstate_nxt = r_wstate;
        w_aw_hs      = 1'b0;
        w_w_hs       = 1'b0;
        w_b_hs       = 1'b0;
        M_AWREADY    = '0;
        M_WREADY     = '0;
        M_BRESP      = '0;
        M_BID        = '0;
        M_BVALID     = '0;
        S_AWADDR     = '0;
        S_AWID       = '0;
        S_AWLEN      = '0;
        S_AWSIZE     = '0;
        S_AWBURST    = '0;
        S_AWVALID    = '0;
        S_WDATA      = '0;
        S_WSTRB      = '0;
        S_WLAST      = '0;
        S_WVALID     = '0;
        S_BREADY     = '0;
        case (r_wstate)
            W_IDLE: begin
                if (|M_AWVALID) w_wstate_nxt = W_ADDR;
            end
            W_ADDR: begin
                if (r_werr) begin
                    M_AWREADY[r_wgnt] = 1'b1;
                end else begin
                    S_AWVALID[r_wslv]                  = M_AWVALID[r_wgnt];
                    S_AWADDR[32*int'(r_wslv) +: 32]    = M_AWADDR[32*int'(r_wgnt) +: 32];
                    S_AWID[IDW*int'(r_wslv) +: IDW]    = M_AWID[IDW*int'(r_wgnt) +: IDW];
                    S_AWLEN[8*int'(r_wslv) +: 8]       = M_AWLEN[8*int'(r_wgnt) +: 8];
                    S_AWSIZE[3*int'(r_wslv) +: 3]      = M_AWSIZE[3*int'(r_wgnt) +: 3];
                    S_AWBURST[2*int'(r_wslv) +: 2]     = M_AWBURST[2*int'(r_wgnt) +: 2];
                    M_AWREADY[r_wgnt]                  = S_AWREADY[r_wslv];
                end
                w_aw_hs = M_AWVALID[r_wgnt] & (r_werr | S_AWREADY[r_wslv]);
                if (w_aw_hs) w_wstate_nxt = W_DATA;
            end
            W_DATA: begin
                // W beats offered earlier were held off by WREADY=0 until now.
                if (r_werr) begin
                    M_WREADY[r_wgnt] = 1'b1;
                end else begin
                    S_WVALID[r_wslv]                 = M_WVALID[r_wgnt];
                    S_WDATA[32*int'(r_wslv) +: 32]   = M_WDATA[32*int'(r_wgnt) +: 32];
                    S_WSTRB[4*int'(r_wslv) +: 4]     = M_WSTRB[4*int'(r_wgnt) +: 4];
                    S_WLAST[r_wslv]                  = M_WLAST[r_wgnt];
                    M_WREADY[r_wgnt]                 = S_WREADY[r_wslv];
                end
                w_w_hs = M_WVALID[r_wgnt] & (r_werr | S_WREADY[r_wslv]);
                if (w_w_hs && M_WLAST[r_wgnt]) w_wstate_nxt = W_RESP;
            end
            W_RESP: begin
                if (r_werr) begin
                    M_BVALID[r_wgnt]                 = 1'b1;
                    M_BRESP[2*int'(r_wgnt) +: 2]     = 2'b11;
                    M_BID[IDW*int'(r_wgnt) +: IDW]   = r_wid;
                end else begin
                    M_BVALID[r_wgnt]                 = S_BVALID[r_wslv];
                    M_BRESP[2*int'(r_wgnt) +: 2]     = S_BRESP[2*int'(r_wslv) +: 2];
                    M_BID[IDW*int'(r_wgnt) +: IDW]   = S_BID[IDW*int'(r_wslv) +: IDW];
                    S_BREADY[r_wslv]                 = M_BREADY[r_wgnt];
                end
                w_b_hs = M_BREADY[r_wgnt] & (r_werr | S_BVALID[r_wslv]);
                if (w_b_hs) w_wstate_nxt = W_IDLE;
            end
            default: w_wstate_nxt = W_IDLE;
        endcase
    end

endmodule
`default_nettype wire
